// File: rtl/ifu_if.sv
// Handshake bundle between the fetch unit, instruction memory, decode and PC redirect logic.
// The master modport is the fetch unit's view; the slave modport is the surrounding system.
interface ifu_if #(
  parameter int CPU_WIDTH = 64
);
  logic                 imem_req_valid;
  logic                 imem_req_ready;
  logic [CPU_WIDTH-1:0] imem_req_addr;
  logic                 imem_rsp_valid;
  logic [31:0]          imem_rsp_data;
  logic                 id_valid;
  logic                 id_ready;
  logic [31:0]          id_ins;
  logic [CPU_WIDTH-1:0] id_pc;
  logic                 redirect_valid;
  logic [CPU_WIDTH-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_ins, id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_ins, id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding imem request at a time, a single-entry
// instruction buffer toward decode, and redirects that may cancel an in-flight fetch.
module ifu #(
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
  parameter int          CPU_WIDTH = 64
) (
  input  logic  clk,
  input  logic  rst,
  ifu_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t               state, state_next;
  logic [CPU_WIDTH-1:0] pc, pc_next;
  logic [31:0]          buffer, buffer_next;
  logic                 drop, drop_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= RESET_PC[CPU_WIDTH-1:0];
      buffer <= NOP;
      drop   <= 1'b0;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      buffer <= buffer_next;
      drop   <= drop_next;
    end
  end

  // Redirect wins over every other transition; drop marks a response that is
  // still owed by memory for an address we no longer want.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    buffer_next = buffer;
    drop_next   = drop;

    if (bus.redirect_valid) begin
      pc_next = bus.redirect_pc & ~CPU_WIDTH'(3);
      case (state)
        IDLE: state_next = REQ;
        REQ: begin
          if (bus.imem_req_ready) begin
            state_next = WAIT;
            drop_next  = 1'b1;
          end else begin
            state_next = REQ;
          end
        end
        WAIT: begin
          if (bus.imem_rsp_valid) begin
            state_next = REQ;
            drop_next  = 1'b0;
          end else begin
            state_next = WAIT;
            drop_next  = 1'b1;
          end
        end
        OUT:     state_next = REQ;
        default: state_next = IDLE;
      endcase
    end else begin
      case (state)
        IDLE: state_next = REQ;
        REQ: begin
          if (bus.imem_req_ready) state_next = WAIT;
        end
        WAIT: begin
          if (bus.imem_rsp_valid) begin
            if (drop) begin
              drop_next  = 1'b0;
              state_next = REQ;
            end else begin
              buffer_next = bus.imem_rsp_data;
              state_next  = OUT;
            end
          end
        end
        OUT: begin
          if (bus.id_ready) begin
            pc_next    = pc + CPU_WIDTH'(4);
            state_next = REQ;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign bus.imem_req_valid = (state == REQ);
  assign bus.imem_req_addr  = pc;
  assign bus.id_valid       = (state == OUT);
  assign bus.id_ins         = buffer;
  assign bus.id_pc          = pc;

endmodule

// File: tb/tb_ifu.sv
// Directed testbench for the fetch unit: drives memory, decode and redirect by hand
// and compares every observed output against hand-computed values.
module tb_ifu;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ifu_if #(.CPU_WIDTH(64)) bus ();

  ifu #(.RESET_PC(RESET_PC), .CPU_WIDTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic req_ready, input logic rsp_valid,
                                input logic [31:0] rsp_data, input logic dec_ready,
                                input logic redir, input logic [63:0] redir_pc);
    bus.imem_req_ready = req_ready;
    bus.imem_rsp_valid = rsp_valid;
    bus.imem_rsp_data  = rsp_data;
    bus.id_ready       = dec_ready;
    bus.redirect_valid = redir;
    bus.redirect_pc    = redir_pc;
  endtask

  task automatic idle_inputs();
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    idle_inputs();

    // Asynchronous reset takes effect before any clock edge
    #2 rst = 1'b1;
    #1;
    check_output("rst_req_valid", 64'(bus.imem_req_valid), 64'h0);
    check_output("rst_id_valid", 64'(bus.id_valid), 64'h0);
    check_output("rst_id_ins", 64'(bus.id_ins), 64'h13);
    check_output("rst_id_pc", bus.id_pc, RESET_PC);
    step();
    rst = 1'b0;
    check_output("idle_req_valid", 64'(bus.imem_req_valid), 64'h0);

    // First fetch: IDLE -> REQ -> WAIT -> OUT
    step();
    check_output("req0_valid", 64'(bus.imem_req_valid), 64'h1);
    check_output("req0_addr", bus.imem_req_addr, 64'h8000_0000);
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    step();
    check_output("wait0_req_valid", 64'(bus.imem_req_valid), 64'h0);
    check_output("wait0_id_valid", 64'(bus.id_valid), 64'h0);
    apply_stimulus(1'b0, 1'b1, 32'h0010_0093, 1'b0, 1'b0, 64'h0);
    step();
    idle_inputs();
    check_output("out0_id_valid", 64'(bus.id_valid), 64'h1);
    check_output("out0_id_ins", 64'(bus.id_ins), 64'h0010_0093);
    check_output("out0_id_pc", bus.id_pc, 64'h8000_0000);

    // Decode stalls for five cycles: everything must hold, no new request
    for (int i = 0; i < 5; i++) begin
      step();
      check_output("stall_id_valid", 64'(bus.id_valid), 64'h1);
      check_output("stall_id_ins", 64'(bus.id_ins), 64'h0010_0093);
      check_output("stall_id_pc", bus.id_pc, 64'h8000_0000);
      check_output("stall_req_valid", 64'(bus.imem_req_valid), 64'h0);
    end
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
    step();
    idle_inputs();
    check_output("req1_valid", 64'(bus.imem_req_valid), 64'h1);
    check_output("req1_addr", bus.imem_req_addr, 64'h8000_0004);

    // Second, unstalled fetch
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    step();
    apply_stimulus(1'b0, 1'b1, 32'h0000_1111, 1'b0, 1'b0, 64'h0);
    step();
    check_output("out1_id_ins", 64'(bus.id_ins), 64'h0000_1111);
    check_output("out1_id_pc", bus.id_pc, 64'h8000_0004);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
    step();
    idle_inputs();
    check_output("req2_addr", bus.imem_req_addr, 64'h8000_0008);

    // Redirect on the same cycle the request is accepted: response must be dropped
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 64'h8000_0100);
    step();
    idle_inputs();
    check_output("rdacc_id_valid", 64'(bus.id_valid), 64'h0);
    check_output("rdacc_req_valid", 64'(bus.imem_req_valid), 64'h0);
    apply_stimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 64'h0);
    step();
    idle_inputs();
    check_output("drop_id_valid", 64'(bus.id_valid), 64'h0);
    check_output("drop_req_valid", 64'(bus.imem_req_valid), 64'h1);
    check_output("drop_req_addr", bus.imem_req_addr, 64'h8000_0100);

    // Redirect while waiting with no response yet: the later response is dropped
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    step();
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 64'h8000_0300);
    step();
    idle_inputs();
    check_output("rdwait_req_valid", 64'(bus.imem_req_valid), 64'h0);
    check_output("rdwait_addr", bus.imem_req_addr, 64'h8000_0300);
    apply_stimulus(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 64'h0);
    step();
    idle_inputs();
    check_output("rdwait_id_valid", 64'(bus.id_valid), 64'h0);
    check_output("rdwait_req2", 64'(bus.imem_req_valid), 64'h1);
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    step();
    apply_stimulus(1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 64'h0);
    step();
    idle_inputs();
    check_output("out3_id_ins", 64'(bus.id_ins), 64'h1111_1111);
    check_output("out3_id_pc", bus.id_pc, 64'h8000_0300);

    // Redirect in OUT with decode ready: no +4, low address bits cleared
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 64'h8000_0203);
    step();
    idle_inputs();
    check_output("rdout_id_valid", 64'(bus.id_valid), 64'h0);
    check_output("rdout_req_valid", 64'(bus.imem_req_valid), 64'h1);
    check_output("rdout_addr", bus.imem_req_addr, 64'h8000_0200);

    // A response outside WAIT is ignored
    apply_stimulus(1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 64'h0);
    step();
    idle_inputs();
    check_output("stray_id_valid", 64'(bus.id_valid), 64'h1 ^ 64'h1);
    check_output("stray_req_valid", 64'(bus.imem_req_valid), 64'h1);

    // PC wrap at the top of the address space
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    idle_inputs();
    check_output("top_addr", bus.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    step();
    apply_stimulus(1'b0, 1'b1, 32'h2222_2222, 1'b0, 1'b0, 64'h0);
    step();
    idle_inputs();
    check_output("top_id_pc", bus.id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
    step();
    idle_inputs();
    check_output("wrap_addr", bus.imem_req_addr, 64'h0);

    // Reset while waiting; a late response after release must be ignored
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    step();
    idle_inputs();
    rst = 1'b1;
    #1;
    check_output("midrst_req_valid", 64'(bus.imem_req_valid), 64'h0);
    check_output("midrst_id_pc", bus.id_pc, RESET_PC);
    step();
    rst = 1'b0;
    apply_stimulus(1'b0, 1'b1, 32'hBADB_AD00, 1'b0, 1'b0, 64'h0);
    step();
    check_output("late_req_valid", 64'(bus.imem_req_valid), 64'h1);
    check_output("late_addr", bus.imem_req_addr, RESET_PC);
    step();
    idle_inputs();
    check_output("late_id_valid", 64'(bus.id_valid), 64'h0);
    check_output("late_still_req", 64'(bus.imem_req_valid), 64'h1);
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    step();
    apply_stimulus(1'b0, 1'b1, 32'h0020_0113, 1'b0, 1'b0, 64'h0);
    step();
    idle_inputs();
    check_output("post_id_valid", 64'(bus.id_valid), 64'h1);
    check_output("post_id_ins", 64'(bus.id_ins), 64'h0020_0113);
    check_output("post_id_pc", bus.id_pc, RESET_PC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
